// File: rtl/mode_selector_if.sv
// Key-event / mode-status bundle for mode_selector.
//   key_down     : 512-bit scan-code bitmap, one bit per code
//   been_ready   : key_down valid this cycle (single-cycle strobe)
//   lock         : freeze the current mode, ignore keys and idle timeout
//   state        : current mode index
//   prev_state   : mode held before the most recent change
//   mode_changed : one-cycle pulse on the cycle after a mode change
interface mode_selector_if #(
  parameter int unsigned STATE_W = 5
);
  logic [511:0]       key_down;
  logic               been_ready;
  logic               lock;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] prev_state;
  logic               mode_changed;

  modport master (
    output key_down, been_ready, lock,
    input  state, prev_state, mode_changed
  );

  modport slave (
    input  key_down, been_ready, lock,
    output state, prev_state, mode_changed
  );
endinterface

// File: rtl/mode_selector.sv
// Display-mode selector driven by keyboard scan-code events.
// Ports:
//   clk  : sole clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset, forces the home mode
//   bus  : mode_selector_if.slave (key events in, registered mode status out)
// ESC returns home, NEXT cycles through modes, entry keys select a mode
// only from home. An optional idle timeout returns to home after
// IDLE_TIMEOUT quiet cycles in a non-home mode.
module mode_selector #(
  parameter int unsigned            NUM_MODES     = 4,
  parameter int unsigned            STATE_W       = 5,
  parameter int unsigned            HOME_MODE     = 2,
  parameter logic [9*NUM_MODES-1:0] MODE_KEYS     = {9'h1B, 9'h000, 9'h1E, 9'h16},
  parameter logic [9*NUM_MODES-1:0] MODE_KEYS_ALT = {9'h000, 9'h000, 9'h72, 9'h69},
  parameter logic [8:0]             ESC_KEY       = 9'h76,
  parameter logic [8:0]             NEXT_KEY      = 9'h0D,
  parameter logic [31:0]            IDLE_TIMEOUT  = 32'd0
) (
  input logic            clk,
  input logic            rst,
  mode_selector_if.slave bus
);

  localparam bit          TIMEOUT_EN = (IDLE_TIMEOUT != 32'd0);
  localparam int unsigned IDLE_W     = TIMEOUT_EN ? $clog2({1'b0, IDLE_TIMEOUT} + 33'd1) : 1;

  localparam logic [STATE_W-1:0] HOME      = STATE_W'(HOME_MODE);
  localparam logic [STATE_W-1:0] LAST      = STATE_W'(NUM_MODES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 32'd1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               changed_q, changed_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;

  logic               key_ev_c;
  logic               illegal_c;
  logic               timeout_c;
  logic               entry_hit_c;
  logic [STATE_W-1:0] entry_mode_c;

  // Entry-key decode: descending scan so the lowest matching mode wins.
  // A zero code means "no key" and never matches.
  always_comb begin : entry_scan
    entry_hit_c  = 1'b0;
    entry_mode_c = HOME;
    for (int i = int'(NUM_MODES) - 1; i >= 0; i--) begin
      if ((i != int'(HOME_MODE)) &&
          (((MODE_KEYS[9*i +: 9] != 9'h000) && bus.key_down[MODE_KEYS[9*i +: 9]]) ||
           ((MODE_KEYS_ALT[9*i +: 9] != 9'h000) && bus.key_down[MODE_KEYS_ALT[9*i +: 9]]))) begin
        entry_hit_c  = 1'b1;
        entry_mode_c = STATE_W'(i);
      end
    end
  end

  // Next mode, change tracking and idle counter.
  always_comb begin : next_state
    state_d   = state_q;
    prev_d    = prev_q;
    changed_d = 1'b0;
    idle_d    = idle_q;

    key_ev_c  = bus.been_ready & ~bus.lock;
    illegal_c = (32'(state_q) >= NUM_MODES);
    timeout_c = TIMEOUT_EN && !bus.lock && (state_q != HOME) && (idle_q == IDLE_LAST);

    if (illegal_c) begin
      state_d = HOME;
    end else if (key_ev_c) begin
      if (bus.key_down[ESC_KEY]) begin
        state_d = HOME;
      end else if (bus.key_down[NEXT_KEY]) begin
        state_d = (state_q == LAST) ? '0 : state_q + STATE_W'(1);
      end else if ((state_q == HOME) && entry_hit_c) begin
        state_d = entry_mode_c;
      end
    end else if (timeout_c) begin
      state_d = HOME;
    end

    if (state_d != state_q) begin
      prev_d    = state_q;
      changed_d = 1'b1;
    end

    // Any activity, home residence or lock restarts the quiet-time count.
    if (!TIMEOUT_EN || key_ev_c || bus.lock || (state_q == HOME) || (state_d != state_q)) begin
      idle_d = '0;
    end else if (idle_q != '1) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HOME;
      prev_q    <= HOME;
      changed_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.prev_state   = prev_q;
  assign bus.mode_changed = changed_q;

endmodule

// File: tb/tb_mode_selector.sv
// Self-checking bench for mode_selector. Two instances share stimulus:
// u_dut0 with the idle timeout disabled, u_dut1 with IDLE_TIMEOUT=16.
// Directed scenarios are checked against constants, and every cycle both
// instances are compared with a behavioural model that tracks mode and the
// cycle number of the last activity.
module tb_mode_selector;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned NMODES  = 4;
  localparam int unsigned HOME    = 2;
  localparam int unsigned ESC     = 'h76;
  localparam int unsigned NEXT    = 'h0D;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic         been_ready;
  logic         lock;

  always #5 clk = ~clk;

  mode_selector_if #(.STATE_W(STATE_W)) bus0 ();
  mode_selector_if #(.STATE_W(STATE_W)) bus1 ();

  mode_selector u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mode_selector #(.IDLE_TIMEOUT(32'd16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state, index 0 = u_dut0, 1 = u_dut1.
  int          m_state [2];
  int          m_prev  [2];
  int          m_chg   [2];
  int          m_last  [2];
  int          tmo     [2];
  int          ncyc;
  int unsigned prim_code [4];
  int unsigned alt_code  [4];
  int unsigned pool      [9];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic [511:0] kd, input logic br, input logic lk);
    key_down        = kd;
    been_ready      = br;
    lock            = lk;
    bus0.key_down   = kd;
    bus0.been_ready = br;
    bus0.lock       = lk;
    bus1.key_down   = kd;
    bus1.been_ready = br;
    bus1.lock       = lk;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_step();
    int e;
    e = ncyc + 1;
    for (int i = 0; i < 2; i++) begin
      int st;
      int nx;
      bit ev;
      bit found;
      st    = m_state[i];
      nx    = st;
      ev    = been_ready && !lock;
      found = 1'b0;
      if (ev) begin
        if (key_down[ESC]) nx = HOME;
        else if (key_down[NEXT]) nx = (st + 1) % NMODES;
        else if (st == HOME) begin
          for (int m = 0; m < NMODES; m++) begin
            if (!found && (m != HOME) &&
                (((prim_code[m] != 0) && key_down[prim_code[m]]) ||
                 ((alt_code[m] != 0) && key_down[alt_code[m]]))) begin
              nx    = m;
              found = 1'b1;
            end
          end
        end
      end else if (!lock && (tmo[i] != 0) && (st != HOME) && (e - m_last[i] == tmo[i])) begin
        nx = HOME;
      end
      if (ev || lock || (st == HOME) || (nx != st)) m_last[i] = e;
      m_chg[i] = (nx != st) ? 1 : 0;
      if (nx != st) m_prev[i] = st;
      m_state[i] = nx;
    end
    ncyc = e;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = HOME;
      m_prev[i]  = HOME;
      m_chg[i]   = 0;
      m_last[i]  = ncyc;
    end
  endtask

  // One clock cycle: predict, clock, then compare both instances.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("st0",   bus0.state,        m_state[0]);
    check("prev0", bus0.prev_state,   m_prev[0]);
    check("chg0",  bus0.mode_changed, m_chg[0]);
    check("st1",   bus1.state,        m_state[1]);
    check("prev1", bus1.prev_state,   m_prev[1]);
    check("chg1",  bus1.mode_changed, m_chg[1]);
  endtask

  // Single key event with up to three keys down (negative = unused).
  task automatic press(input int a, input int b = -1, input int c = -1);
    logic [511:0] kd;
    kd = '0;
    if (a >= 0) kd[a] = 1'b1;
    if (b >= 0) kd[b] = 1'b1;
    if (c >= 0) kd[c] = 1'b1;
    drive(kd, 1'b1, 1'b0);
    cycle();
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    drive('0, 1'b0, 1'b0);
    repeat (n) cycle();
  endtask

  initial begin
    logic [511:0] kd;
    bit           seen;

    prim_code = '{'h16, 'h1E, 0, 'h1B};
    alt_code  = '{'h69, 'h72, 0, 0};
    pool      = '{0, 'h16, 'h1E, 'h69, 'h72, 'h1B, 'h76, 'h0D, 0};
    tmo       = '{0, 16};
    ncyc      = 0;

    rst = 1'b0;
    drive('0, 1'b0, 1'b0);
    model_reset();
    #22;
    check("rst_st0",   bus0.state,        HOME);
    check("rst_prev0", bus0.prev_state,   HOME);
    check("rst_chg0",  bus0.mode_changed, 0);
    check("rst_st1",   bus1.state,        HOME);
    check("rst_prev1", bus1.prev_state,   HOME);
    check("rst_chg1",  bus1.mode_changed, 0);
    @(negedge clk);
    rst = 1'b1;

    // Primary entry key from home.
    press('h16);
    check("ent_st",   bus0.state,        0);
    check("ent_chg",  bus0.mode_changed, 1);
    check("ent_prev", bus0.prev_state,   2);
    idle(1);
    check("ent_pulse", bus0.mode_changed, 0);

    // NEXT cycling with wrap, then ESC.
    press(NEXT); press(NEXT); press(NEXT);
    check("nx_to3", bus0.state, 3);
    press(NEXT);
    check("nx_wrap", bus0.state, 0);
    press(NEXT);
    check("nx_1", bus0.state, 1);
    press(ESC);
    check("esc_home", bus0.state, 2);

    // Lowest entry index wins; ESC beats NEXT and entry keys.
    press('h16, 'h1E);
    check("ent_lowest", bus0.state, 0);
    press(NEXT);
    press(ESC, NEXT, 'h1E);
    check("esc_prio",      bus0.state,      2);
    check("esc_prio_prev", bus0.prev_state, 1);

    // Idle timeout on u_dut1.
    press('h1E);
    idle(15);
    check("to_hold", bus1.state, 1);
    idle(1);
    check("to_home",   bus1.state,        2);
    check("to_chg",    bus1.mode_changed, 1);
    check("to_prev",   bus1.prev_state,   1);
    check("to_off",    bus0.state,        1);
    press(ESC);
    check("esc_in_home", bus1.mode_changed, 0);

    // Event on the last quiet cycle restarts the count.
    press('h1E);
    idle(15);
    press(-1);
    check("to_kick_st",  bus1.state,        1);
    check("to_kick_chg", bus1.mode_changed, 0);
    idle(15);
    check("to_restart_hold", bus1.state, 1);
    idle(1);
    check("to_restart_home", bus1.state, 2);

    // Lock freezes the mode against ESC events and idle time.
    press(ESC);
    press('h16);
    seen = 1'b0;
    kd = '0;
    kd[ESC] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drive(kd, 1'($urandom_range(0, 1)), 1'b1);
      cycle();
      if (bus1.mode_changed || bus0.mode_changed) seen = 1'b1;
    end
    check("lock_st1",  bus1.state, 0);
    check("lock_st0",  bus0.state, 0);
    check("lock_quiet", 32'(seen), 0);
    drive('0, 1'b0, 1'b0);

    // Asynchronous reset between edges from mode 3.
    press(NEXT); press(NEXT); press(NEXT);
    check("pre_rst_st", bus0.state, 3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_st0",   bus0.state,        HOME);
    check("arst_prev0", bus0.prev_state,   HOME);
    check("arst_chg0",  bus0.mode_changed, 0);
    check("arst_st1",   bus1.state,        HOME);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Scan code 0 must never act as an entry key.
    press(0);
    press(0, 'h2A);
    check("code0_st",  bus0.state,        HOME);
    check("code0_chg", bus0.mode_changed, 0);

    // Randomised traffic, compared against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        idle(int'($urandom_range(17, 20)));
      end else begin
        kd = '0;
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
          pool[8] = $urandom_range(0, 511);
          kd[pool[$urandom_range(0, 8)]] = 1'b1;
        end
        drive(kd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mode_selector.md
MODE_SELECTOR -- requirements
Module: mode_selector

Interface
REQ-001 Parameter NUM_MODES, default 4, number of display modes (2..32); legal states 0..NUM_MODES-1.
REQ-002 Parameter STATE_W, default 5, width of state outputs; SHALL satisfy 2^STATE_W >= NUM_MODES.
REQ-003 Parameter HOME_MODE, default 2, showoff/home mode index.
REQ-004 Parameter MODE_KEYS, default {9'h1B,9'h000,9'h1E,9'h16} (mode3..mode0), packed 9-bit primary entry scan code per mode; code 9'h000 = none.
REQ-005 Parameter MODE_KEYS_ALT, default {9'h000,9'h000,9'h72,9'h69}, packed 9-bit alternate entry code per mode; 9'h000 = none.
REQ-006 Parameter ESC_KEY, default 9'h76, return-home key; NEXT_KEY, default 9'h0D, cycle-mode key.
REQ-007 Parameter IDLE_TIMEOUT, default 0, 32-bit idle cycles before auto-return home; 0 disables.
REQ-008 clk  input  1  sole clock, all state on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-low.
REQ-010 key_down  input  512  one bit per scan code, high = key pressed this event.
REQ-011 been_ready  input  1  key_down valid this cycle (one-cycle event strobe).
REQ-012 lock  input  1  high = freeze mode, ignore all keys and timeout.
REQ-013 state  output  STATE_W  current mode, registered.
REQ-014 prev_state  output  STATE_W  mode before last change, registered.
REQ-015 mode_changed  output  1  one-cycle pulse, registered.

Function
REQ-016 Key event = been_ready=1 and lock=0; key_down ignored otherwise.
REQ-017 Priority per event: ESC_KEY > NEXT_KEY > entry keys.
REQ-018 ESC_KEY in non-home state -> HOME_MODE next edge; in HOME_MODE -> no change.
REQ-019 NEXT_KEY in any state -> (state+1), wrapping NUM_MODES-1 -> 0.
REQ-020 Entry keys honoured only in HOME_MODE: lowest mode index i (i != HOME_MODE) whose primary or alternate code bit is set -> state i; HOME_MODE's own codes ignored.
REQ-021 Entry keys in non-home states ignored (state held).
REQ-022 Code 9'h000 in MODE_KEYS/MODE_KEYS_ALT never matches, even if key_down[0]=1.
REQ-023 Idle counter, width clog2(IDLE_TIMEOUT+1): cleared on every key event, on any state change, and while in HOME_MODE or lock=1; increments otherwise, saturating.
REQ-024 Counter reaching IDLE_TIMEOUT-1 in non-home state with no key event that cycle -> HOME_MODE next edge; key event same cycle wins over timeout.
REQ-025 IDLE_TIMEOUT=0: counter held at 0, no auto-return.
REQ-026 state >= NUM_MODES (illegal) -> HOME_MODE next edge regardless of lock/keys.
REQ-027 On every edge where state changes: prev_state <= old state, mode_changed <= 1; otherwise mode_changed <= 0, prev_state held.
REQ-028 Latency: key event in cycle N -> new state and mode_changed=1 visible after edge N+1; no combinational path from inputs to outputs.
REQ-029 Key event producing no state change (e.g. ESC in home, NEXT with NUM_MODES... always changes) -> mode_changed stays 0.

Reset
REQ-030 rst=0 asynchronously forces state=HOME_MODE, prev_state=HOME_MODE, mode_changed=0, idle counter=0, independent of clk.
REQ-031 Reset assertion mid-operation (including mid-timeout count) discards pending transition; first edge after release evaluates normally.

Verification
REQ-032 Reset, then been_ready=1 with key_down[9'h16]=1 -> state 2->0, mode_changed=1 one cycle, prev_state=2.
REQ-033 In state 3, pulse NEXT_KEY (9'h0D) -> state 0 (wrap); pulse again -> 1; ESC (9'h76) -> 2.
REQ-034 In home, key_down[9'h16] and [9'h1E] together -> state 0; ESC+NEXT+9'h1E together in state 1 -> state 2.
REQ-035 IDLE_TIMEOUT=16, enter state 1, no events -> state 2 exactly 16 cycles after entry; repeat with been_ready pulse on cycle 15 -> stays 1, count restarts.
REQ-036 lock=1 in state 0 with ESC events and 100 idle cycles (IDLE_TIMEOUT=16) -> state stays 0, mode_changed never 1.
REQ-037 Assert rst low between clock edges while in state 3 -> state=2 immediately, before next rising edge; key_down[0]=1 events in home -> no change.
